benes_cfg_seq: RTL and testbench
================================

BENES_CFG_SEQ -- requirements
Module: benes_cfg_seq

Interface
REQ-001 Parameter CFG_SLOTS, default 4: number of stored permutation configurations.
REQ-002 Parameter NET_LATENCY, default 1: Benes datapath latency in clk cycles (0 allowed).
REQ-003 Parameter BEAT_W, default 8: width of the beat counter.
REQ-004 clk  in  1  single clock, all state rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_wr_en  in  1  write one stage word into config memory.
REQ-007 cfg_wr_slot  in  $clog2(CFG_SLOTS)  target slot.
REQ-008 cfg_wr_stage  in  $clog2(STAGE_NUM)  target stage index.
REQ-009 cfg_wr_data  in  SWITCH_NUM  switch control bits for that stage.
REQ-010 cfg_wr_err  out  1  one-cycle pulse, write rejected.
REQ-011 req_valid / req_ready  in / out  1  permutation-job handshake.
REQ-012 req_slot  in  $clog2(CFG_SLOTS)  config slot for the job.
REQ-013 req_beats  in  BEAT_W  number of data vectors to route.
REQ-014 in_valid / in_ready  in / out  1  upstream data-vector handshake.
REQ-015 net_valid  out  1  qualifies the vector entering the Benes network.
REQ-016 switch_set  out  [SWITCH_NUM-1:0] x [0:STAGE_NUM-1]  registered Benes switch controls.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at job completion.

Function
REQ-019 FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-020 req_ready = 1 only in IDLE; job accepted on req_valid & req_ready; slot and beats latched.
REQ-021 IDLE -> LOAD on acceptance; LOAD lasts 1 cycle and copies all STAGE_NUM words of the slot into switch_set.
REQ-022 LOAD -> STREAM if beats != 0; LOAD -> DONE if beats == 0 (no net_valid issued).
REQ-023 STREAM: in_ready = 1; net_valid = in_valid & in_ready, combinational; each transfer decrements the beat count.
REQ-024 STREAM -> DRAIN in the cycle after the last beat transfers; -> DONE directly if NET_LATENCY == 0.
REQ-025 DRAIN counts exactly NET_LATENCY cycles, then -> DONE.
REQ-026 DONE: done = 1 for one cycle, then -> IDLE.
REQ-027 switch_set changes only in LOAD; it holds stable through STREAM, DRAIN, DONE and IDLE.
REQ-028 Config writes are accepted in any state unless the slot is the active slot and the state is LOAD, STREAM or DRAIN; such a write is dropped and cfg_wr_err pulses.
REQ-029 cfg_wr_stage >= STAGE_NUM: write dropped, cfg_wr_err pulses.
REQ-030 A write and a LOAD of the same slot in the same cycle: LOAD takes the pre-write contents and the write is rejected per REQ-028.
REQ-031 in_ready = 0 outside STREAM; in_valid is ignored there.

Reset
REQ-032 rst asserted: state IDLE; switch_set, config memory and counters all 0; req_ready = 1; in_ready, net_valid, done, cfg_wr_err and busy = 0.
REQ-033 rst mid-job aborts immediately; no done pulse; first cycle after deassertion accepts a new request.

Structure
REQ-034 SIZE, STAGE_NUM, SWITCH_NUM and DATA_WIDTH come from USER_PKG; the FSM state enum and the CFG_SLOTS default go in USER_PKG.
REQ-035 Config memory is one sub-module benes_cfg_mem: synchronous write, combinational read of all stages of one slot.

Verification
REQ-036 Write slot 0 with stage words A300,00A8,E0E4,183C,1014,1014,2020,2810,2D00; request slot 0, beats 32 -> those words appear on switch_set at LOAD+1, and there are 32 net_valid pulses.
REQ-037 Request beats 0 -> sequence LOAD then DONE; done pulses 2 cycles after acceptance; net_valid is never asserted.
REQ-038 NET_LATENCY = 3, beats 2, in_valid toggling -> done pulses 4 cycles after the second transfer (3 DRAIN cycles + DONE).
REQ-039 Write to active slot during STREAM -> cfg_wr_err pulse, memory unchanged; write to slot 1 in the same job -> accepted.
REQ-040 cfg_wr_stage = 9 -> cfg_wr_err pulse, no memory change.
REQ-041 rst asserted mid-STREAM -> all outputs at reset values within the same cycle, no done pulse; the next request completes normally.

Source files
------------

// File: rtl/benes_cfg_seq_pkg.sv
// Shared network geometry, FSM state encoding and helpers for the Benes
// configuration sequencer (32-port network: 9 stages of 16 switches).
package user_pkg;

  localparam int SIZE              = 32;
  localparam int DATA_WIDTH        = 8;
  localparam int STAGE_NUM         = 2 * $clog2(SIZE) - 1;
  localparam int SWITCH_NUM        = SIZE / 2;
  localparam int STAGE_W           = $clog2(STAGE_NUM);
  localparam int CFG_SLOTS_DEFAULT = 4;

  typedef logic [SWITCH_NUM-1:0] stage_word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  function automatic logic stage_in_range(input logic [STAGE_W-1:0] stage);
    return stage < STAGE_W'(STAGE_NUM);
  endfunction

endpackage

// File: rtl/benes_cfg_mem.sv
// Per-slot switch configuration store: one stage word written per cycle,
// every stage of the selected slot readable combinationally.
module benes_cfg_mem
  import user_pkg::*;
#(
  parameter int CFG_SLOTS = CFG_SLOTS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(CFG_SLOTS)-1:0] wr_slot,
  input  logic [STAGE_W-1:0]           wr_stage,
  input  stage_word_t                  wr_data,
  input  logic [$clog2(CFG_SLOTS)-1:0] rd_slot,
  output stage_word_t                  rd_data [0:STAGE_NUM-1]
);

  stage_word_t mem [0:CFG_SLOTS-1][0:STAGE_NUM-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < CFG_SLOTS; s++) begin
        for (int g = 0; g < STAGE_NUM; g++) begin
          mem[s][g] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_slot][wr_stage] <= wr_data;
    end
  end

  always_comb begin
    for (int g = 0; g < STAGE_NUM; g++) begin
      rd_data[g] = mem[rd_slot][g];
    end
  end

endmodule

// File: rtl/benes_cfg_seq.sv
// Job sequencer for a Benes permutation network: loads a stored slot into the
// switch controls, streams the requested number of vectors, waits out the
// network latency and reports completion.
module benes_cfg_seq
  import user_pkg::*;
#(
  parameter int CFG_SLOTS   = CFG_SLOTS_DEFAULT,
  parameter int NET_LATENCY = 1,
  parameter int BEAT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(CFG_SLOTS)-1:0] cfg_wr_slot,
  input  logic [STAGE_W-1:0]           cfg_wr_stage,
  input  logic [SWITCH_NUM-1:0]        cfg_wr_data,
  output logic                         cfg_wr_err,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(CFG_SLOTS)-1:0] req_slot,
  input  logic [BEAT_W-1:0]            req_beats,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         net_valid,
  output logic [SWITCH_NUM-1:0]        switch_set [0:STAGE_NUM-1],
  output logic                         busy,
  output logic                         done
);

  localparam int SLOT_W = $clog2(CFG_SLOTS);
  localparam int CNT_W  = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((NET_LATENCY > 0) ? NET_LATENCY - 1 : 0);

  state_t             state, state_nxt;
  logic [SLOT_W-1:0]  slot_q;
  logic [BEAT_W-1:0]  beats_q;
  logic [CNT_W-1:0]   drain_cnt;
  stage_word_t        rd_data [0:STAGE_NUM-1];
  logic               job_active;
  logic               wr_reject;

  // The slot feeding the switches must not change while a job depends on it.
  assign job_active = (state == LOAD) || (state == STREAM) || (state == DRAIN);
  assign wr_reject  = !stage_in_range(cfg_wr_stage) || (job_active && (cfg_wr_slot == slot_q));
  assign net_valid  = in_valid & in_ready;

  benes_cfg_mem #(
    .CFG_SLOTS (CFG_SLOTS)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_wr_en & ~wr_reject),
    .wr_slot  (cfg_wr_slot),
    .wr_stage (cfg_wr_stage),
    .wr_data  (cfg_wr_data),
    .rd_slot  (slot_q),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = (beats_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid && (beats_q == BEAT_W'(1))) begin
          state_nxt = (NET_LATENCY == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot_q     <= '0;
      beats_q    <= '0;
      drain_cnt  <= '0;
      cfg_wr_err <= 1'b0;
      for (int g = 0; g < STAGE_NUM; g++) begin
        switch_set[g] <= '0;
      end
    end else begin
      state      <= state_nxt;
      cfg_wr_err <= cfg_wr_en & wr_reject;
      if (state == IDLE && req_valid) begin
        slot_q  <= req_slot;
        beats_q <= req_beats;
      end
      if (state == STREAM && in_valid) begin
        beats_q <= beats_q - BEAT_W'(1);
      end
      // Memory read is combinational, so a same-cycle write never leaks in here.
      if (state == LOAD) begin
        for (int g = 0; g < STAGE_NUM; g++) begin
          switch_set[g] <= rd_data[g];
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + CNT_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_benes_cfg_seq.sv
// Scoreboard bench for benes_cfg_seq: randomized jobs and config writes
// against a slot-memory / job-timeline reference model.
module tb_benes_cfg_seq;
  import user_pkg::*;

  localparam int L     = 3;
  localparam int SLOTS = 4;
  localparam int BW    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_wr_en;
  logic [1:0]        cfg_wr_slot;
  logic [STAGE_W-1:0] cfg_wr_stage;
  logic [SWITCH_NUM-1:0] cfg_wr_data;
  logic              cfg_wr_err;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_slot;
  logic [BW-1:0]     req_beats;
  logic              in_valid;
  logic              in_ready;
  logic              net_valid;
  logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1];
  logic              busy;
  logic              done;

  benes_cfg_seq #(
    .CFG_SLOTS   (SLOTS),
    .NET_LATENCY (L),
    .BEAT_W      (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_slot  (cfg_wr_slot),
    .cfg_wr_stage (cfg_wr_stage),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_err   (cfg_wr_err),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_slot     (req_slot),
    .req_beats    (req_beats),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .net_valid    (net_valid),
    .switch_set   (switch_set),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    int beats;
    logic [STAGE_NUM*SWITCH_NUM-1:0] words;
  } job_t;

  typedef struct {
    int cyc;
    bit err;
  } err_t;

  job_t        jq[$];
  err_t        eq[$];
  stage_word_t model [0:SLOTS-1][0:STAGE_NUM-1];
  int          tests = 0;
  int          fails = 0;
  int          acc = 0, done_at = 0, jslot = 0;
  bit          done_known = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes the scoreboard whenever the DUT reports an event.
  int   nv_cnt = 0;
  job_t mj;
  err_t me;
  always @(negedge clk) begin
    if (rst) begin
      nv_cnt = 0;
    end else begin
      if (net_valid) nv_cnt++;
      if (done) begin
        if (jq.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          mj = jq.pop_front();
          check("done_cycle", cyc, mj.done_cyc);
          check("net_valid_count", nv_cnt, mj.beats);
          for (int g = 0; g < STAGE_NUM; g++)
            check($sformatf("switch_set[%0d]", g), switch_set[g], mj.words[g*SWITCH_NUM +: SWITCH_NUM]);
        end
        nv_cnt = 0;
      end
      if (eq.size() != 0 && eq[0].cyc == cyc) begin
        me = eq.pop_front();
        check("cfg_wr_err", cfg_wr_err, me.err);
      end else begin
        check("cfg_wr_err_idle", cfg_wr_err, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  function automatic bit job_busy(input int c);
    return (c > acc) && (!done_known || c < done_at);
  endfunction

  task automatic apply_write(input int slot, input int stage, input logic [15:0] data, input bit in_job);
    err_t e;
    bit   rej;
    rej = (stage >= STAGE_NUM) || (in_job && slot == jslot);
    cfg_wr_en    = 1'b1;
    cfg_wr_slot  = 2'(slot);
    cfg_wr_stage = STAGE_W'(stage);
    cfg_wr_data  = data;
    e.cyc = cyc + 1;
    e.err = rej;
    eq.push_back(e);
    if (!rej) model[slot][stage] = data;
  endtask

  task automatic idle_write(input int slot, input int stage, input logic [15:0] data);
    step();
    apply_write(slot, stage, data, 1'b0);
  endtask

  // wmode: 0 none, 1 write during LOAD, 2 write in the cycle after LOAD
  task automatic run_job(input int slot, input int beats, input int wmode,
                         input int wslot, input int wstage, input logic [15:0] wdata);
    job_t j;
    int   rem;
    int   c;
    step();
    req_valid  = 1'b1;
    req_slot   = 2'(slot);
    req_beats  = BW'(beats);
    acc        = cyc;
    jslot      = slot;
    done_known = 1'b0;
    j.beats    = beats;
    for (int g = 0; g < STAGE_NUM; g++) j.words[g*SWITCH_NUM +: SWITCH_NUM] = model[slot][g];
    if (beats == 0) begin
      done_at    = acc + 2;
      done_known = 1'b1;
      j.done_cyc = done_at;
      jq.push_back(j);
    end
    @(negedge clk);
    check("req_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    in_valid  = 1'($urandom % 2);
    if (wmode == 1) apply_write(wslot, wstage, wdata, job_busy(cyc));
    rem = beats;
    while (!done_known || cyc < done_at) begin
      step();
      c = cyc;
      if (wmode == 2 && c == acc + 2) apply_write(wslot, wstage, wdata, job_busy(c));
      if (rem > 0) begin
        in_valid = (($urandom % 4) != 0) || (c - acc > 4 * beats + 16);
        if (in_valid) begin
          rem--;
          if (rem == 0) begin
            done_at    = c + L + 1;
            done_known = 1'b1;
            j.done_cyc = done_at;
            jq.push_back(j);
          end
        end
      end else begin
        in_valid = 1'($urandom % 2);
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_net_valid"}, net_valid, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_cfg_wr_err"}, cfg_wr_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    for (int g = 0; g < STAGE_NUM; g++)
      check($sformatf("%s_switch_set[%0d]", tag, g), switch_set[g], '0);
  endtask

  task automatic clear_model();
    for (int s = 0; s < SLOTS; s++)
      for (int g = 0; g < STAGE_NUM; g++) model[s][g] = '0;
  endtask

  logic [15:0] golden [0:8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    golden = '{16'hA300, 16'h00A8, 16'hE0E4, 16'h183C, 16'h1014,
               16'h1014, 16'h2020, 16'h2810, 16'h2D00};
    clear_model();
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_slot = '0; cfg_wr_stage = '0; cfg_wr_data = '0;
    req_valid = 1'b0; req_slot = '0; req_beats = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    in_valid = 1'b0;

    // Golden configuration, 32 beats
    for (int g = 0; g < STAGE_NUM; g++) idle_write(0, g, golden[g]);
    run_job(0, 32, 0, 0, 0, 16'h0);
    // Zero-beat job
    run_job(3, 0, 0, 0, 0, 16'h0);
    // Out-of-range stage, then confirm slot 1 untouched
    idle_write(1, 9, 16'hFFFF);
    run_job(1, 2, 0, 0, 0, 16'h0);
    // Writes during a job: active slot rejected, other slot accepted
    run_job(0, 6, 2, 0, 3, 16'hBEEF);
    run_job(0, 4, 2, 1, 5, 16'h1234);
    run_job(1, 1, 0, 0, 0, 16'h0);
    run_job(0, 3, 0, 0, 0, 16'h0);
    // Write to the loading slot in the LOAD cycle
    idle_write(2, 0, 16'h0F0F);
    run_job(2, 3, 1, 2, 0, 16'h5555);
    run_job(2, 0, 0, 0, 0, 16'h0);

    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = $urandom % 3;
      for (int k = 0; k < nw; k++)
        idle_write($urandom % SLOTS, $urandom % 12, 16'($urandom));
      run_job($urandom % SLOTS, $urandom % 20, $urandom % 3,
              $urandom % SLOTS, $urandom % 11, 16'($urandom));
    end

    // Reset in the middle of a stream
    step();
    req_valid = 1'b1; req_slot = 2'd0; req_beats = BW'(10);
    step();
    req_valid = 1'b0;
    step();
    in_valid = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    run_job(0, 5, 0, 0, 0, 16'h0);
    idle_write(0, 4, 16'hC3C3);
    run_job(0, 7, 0, 0, 0, 16'h0);

    repeat (6) step();
    check("jobs_outstanding", jq.size(), 0);
    check("writes_outstanding", eq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
